// File: rtl/score_history_if.sv
// Bundles the score history control inputs and display/status outputs.
// The master side drives the write, replay and clear requests; the slave side is the history block.
interface score_history_if #(
  parameter int SCORE_W = 10
);
  logic               wr_en;
  logic [SCORE_W-1:0] wr_score;
  logic [SCORE_W-1:0] live_score;
  logic               replay;
  logic               clear;
  logic [SCORE_W-1:0] disp_score;
  logic [3:0]         disp_idx;
  logic               replaying;
  logic [4:0]         count;
  logic               full;
  logic [SCORE_W-1:0] best_score;
  logic [3:0]         best_idx;

  modport master (
    output wr_en, wr_score, live_score, replay, clear,
    input  disp_score, disp_idx, replaying, count, full, best_score, best_idx
  );

  modport slave (
    input  wr_en, wr_score, live_score, replay, clear,
    output disp_score, disp_idx, replaying, count, full, best_score, best_idx
  );
endinterface

// File: rtl/score_history.sv
// Ring buffer of the last NUM_ROUNDS round scores with best-score tracking
// and a timed replay that steps through the stored rounds oldest first.
module score_history #(
  parameter int NUM_ROUNDS = 4,
  parameter int SCORE_W    = 10,
  parameter int DWELL      = 3
) (
  input  logic            clk,
  input  logic            reset_n,
  score_history_if.slave  bus
);

  localparam int PTR_W = (NUM_ROUNDS > 1) ? $clog2(NUM_ROUNDS) : 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_ROUNDS - 1);
  localparam logic [4:0]       CNT_MAX  = 5'(NUM_ROUNDS);
  localparam logic [15:0]      DC_LAST  = 16'(DWELL - 1);

  typedef enum logic {
    IDLE,
    REPLAY
  } state_t;

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   wp_q, wp_d;
  logic [PTR_W-1:0]   op_q, op_d;
  logic [PTR_W-1:0]   ro_q, ro_d;
  logic [15:0]        dc_q, dc_d;
  logic [4:0]         cnt_q, cnt_d;
  logic [3:0]         rnd_q, rnd_d;
  logic [SCORE_W-1:0] best_q, best_d;
  logic [3:0]         best_idx_q, best_idx_d;
  logic [SCORE_W-1:0] disp_q, disp_d;
  logic [3:0]         disp_idx_q, disp_idx_d;

  logic [SCORE_W-1:0] mem_q [NUM_ROUNDS];

  logic               wr_fire;
  logic               is_full;
  logic [PTR_W:0]     rd_sum;
  logic [PTR_W-1:0]   rd_idx;

  function automatic logic [PTR_W-1:0] inc_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  assign wr_fire = bus.wr_en && !bus.clear;
  assign is_full = (cnt_q == CNT_MAX);

  always_comb begin
    wp_d       = wp_q;
    op_d       = op_q;
    cnt_d      = cnt_q;
    rnd_d      = rnd_q;
    best_d     = best_q;
    best_idx_d = best_idx_q;

    if (bus.clear) begin
      wp_d       = '0;
      op_d       = '0;
      cnt_d      = '0;
      rnd_d      = '0;
      best_d     = '0;
      best_idx_d = '0;
    end else if (bus.wr_en) begin
      wp_d  = inc_ptr(wp_q);
      rnd_d = rnd_q + 4'd1;
      if (is_full) begin
        op_d = inc_ptr(op_q);
      end else begin
        cnt_d = cnt_q + 5'd1;
      end
      // An empty history means this is the first write since clear/reset.
      if ((cnt_q == 5'd0) || (bus.wr_score > best_q)) begin
        best_d     = bus.wr_score;
        best_idx_d = rnd_q;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ro_d    = ro_q;
    dc_d    = dc_q;

    case (state_q)
      IDLE: begin
        ro_d = '0;
        dc_d = '0;
        if (!bus.clear && bus.replay && (cnt_q != 5'd0)) begin
          state_d = REPLAY;
        end
      end
      REPLAY: begin
        if (bus.clear || !bus.replay) begin
          state_d = IDLE;
          ro_d    = '0;
          dc_d    = '0;
        end else if (dc_q == DC_LAST) begin
          dc_d = '0;
          ro_d = ((5'(ro_q) + 5'd1) == cnt_q) ? '0 : ro_q + PTR_W'(1);
        end else begin
          dc_d = dc_q + 16'd1;
        end
      end
      default: begin
        state_d = IDLE;
        ro_d    = '0;
        dc_d    = '0;
      end
    endcase
  end

  // The display follows the next-cycle state, so a same-cycle write to the
  // read slot is forwarded instead of showing the stale memory word.
  always_comb begin
    rd_sum = {1'b0, op_d} + {1'b0, ro_d};
    if (rd_sum >= (PTR_W + 1)'(NUM_ROUNDS)) begin
      rd_sum = rd_sum - (PTR_W + 1)'(NUM_ROUNDS);
    end
    rd_idx = rd_sum[PTR_W-1:0];

    disp_d     = bus.live_score;
    disp_idx_d = 4'd0;
    if (state_d == REPLAY) begin
      disp_idx_d = 4'(ro_d);
      if (wr_fire && (rd_idx == wp_q)) begin
        disp_d = bus.wr_score;
      end else begin
        disp_d = mem_q[rd_idx];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      wp_q       <= '0;
      op_q       <= '0;
      ro_q       <= '0;
      dc_q       <= '0;
      cnt_q      <= '0;
      rnd_q      <= '0;
      best_q     <= '0;
      best_idx_q <= '0;
      disp_q     <= '0;
      disp_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      wp_q       <= wp_d;
      op_q       <= op_d;
      ro_q       <= ro_d;
      dc_q       <= dc_d;
      cnt_q      <= cnt_d;
      rnd_q      <= rnd_d;
      best_q     <= best_d;
      best_idx_q <= best_idx_d;
      disp_q     <= disp_d;
      disp_idx_q <= disp_idx_d;
    end
  end

  // Storage needs no reset: slots at or beyond count are never read.
  always_ff @(posedge clk) begin
    if (reset_n && wr_fire) begin
      mem_q[wp_q] <= bus.wr_score;
    end
  end

  assign bus.disp_score = disp_q;
  assign bus.disp_idx   = disp_idx_q;
  assign bus.replaying  = (state_q == REPLAY);
  assign bus.count      = cnt_q;
  assign bus.full       = is_full;
  assign bus.best_score = best_q;
  assign bus.best_idx   = best_idx_q;

endmodule

// File: tb/tb_score_history.sv
// Directed bench for score_history with 4 rounds, 10-bit scores and a
// 3-cycle dwell; every expected value below is worked out by hand.
module tb_score_history;

  localparam int SW = 10;

  logic clk = 1'b0;
  logic reset_n;
  int   total = 0;
  int   bad   = 0;

  int seq_a   [4]  = '{12, 40, 7, 40};
  int ovr_val [10] = '{40, 7, 7, 7, 40, 40, 40, 99, 99, 99};
  int ovr_idx [10] = '{0, 1, 1, 1, 2, 2, 2, 3, 3, 3};
  int wrap_v  [4]  = '{2, 3, 4, 5};

  score_history_if #(.SCORE_W(SW)) bus ();

  score_history #(
    .NUM_ROUNDS(4),
    .SCORE_W   (SW),
    .DWELL     (3)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic wr, input int score, input logic rp, input logic clr);
    bus.wr_en    = wr;
    bus.wr_score = SW'(score);
    bus.replay   = rp;
    bus.clear    = clr;
    tick();
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " disp"},      32'(bus.disp_score), 0);
    checkOutput({tag, " idx"},       32'(bus.disp_idx),   0);
    checkOutput({tag, " replaying"}, 32'(bus.replaying),  0);
    checkOutput({tag, " count"},     32'(bus.count),      0);
    checkOutput({tag, " full"},      32'(bus.full),       0);
    checkOutput({tag, " best"},      32'(bus.best_score), 0);
    checkOutput({tag, " best_idx"},  32'(bus.best_idx),   0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset_n        = 1'b1;
    bus.wr_en      = 1'b0;
    bus.wr_score   = '0;
    bus.live_score = SW'(77);
    bus.replay     = 1'b0;
    bus.clear      = 1'b0;
    #1 reset_n = 1'b0;
    #3;
    checkAllZero("reset");
    @(posedge clk);
    @(posedge clk);
    #1 reset_n = 1'b1;

    // Fill the history: 12, 40, 7, 40 (tie on 40 keeps round 1)
    applyStimulus(1'b1, 12, 1'b0, 1'b0);
    checkOutput("first write count", 32'(bus.count), 1);
    checkOutput("first write best", 32'(bus.best_score), 12);
    checkOutput("first write best_idx", 32'(bus.best_idx), 0);
    applyStimulus(1'b1, 40, 1'b0, 1'b0);
    applyStimulus(1'b1, 7, 1'b0, 1'b0);
    applyStimulus(1'b1, 40, 1'b0, 1'b0);
    bus.wr_en = 1'b0;
    checkOutput("fill count", 32'(bus.count), 4);
    checkOutput("fill full", 32'(bus.full), 1);
    checkOutput("fill best", 32'(bus.best_score), 40);
    checkOutput("fill best_idx", 32'(bus.best_idx), 1);
    checkOutput("idle live", 32'(bus.disp_score), 77);
    checkOutput("idle replaying", 32'(bus.replaying), 0);

    // Replay cycles oldest to newest, 3 cycles per entry
    for (int i = 0; i < 15; i++) begin
      applyStimulus(1'b0, 0, 1'b1, 1'b0);
      checkOutput($sformatf("replay val %0d", i), 32'(bus.disp_score), 32'(seq_a[(i / 3) % 4]));
      checkOutput($sformatf("replay idx %0d", i), 32'(bus.disp_idx), 32'((i / 3) % 4));
      checkOutput($sformatf("replay flag %0d", i), 32'(bus.replaying), 1);
    end
    applyStimulus(1'b0, 0, 1'b0, 1'b0);
    checkOutput("replay exit flag", 32'(bus.replaying), 0);
    checkOutput("replay exit disp", 32'(bus.disp_score), 77);
    checkOutput("replay exit idx", 32'(bus.disp_idx), 0);

    // Overwrite the displayed oldest entry with 99 during replay
    applyStimulus(1'b0, 0, 1'b1, 1'b0);
    checkOutput("ovr start disp", 32'(bus.disp_score), 12);
    applyStimulus(1'b1, 99, 1'b1, 1'b0);
    bus.wr_en = 1'b0;
    checkOutput("ovr shift disp", 32'(bus.disp_score), 40);
    checkOutput("ovr shift idx", 32'(bus.disp_idx), 0);
    checkOutput("ovr count", 32'(bus.count), 4);
    checkOutput("ovr best", 32'(bus.best_score), 99);
    checkOutput("ovr best_idx", 32'(bus.best_idx), 4);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 0, 1'b1, 1'b0);
      checkOutput($sformatf("ovr val %0d", i), 32'(bus.disp_score), 32'(ovr_val[i]));
      checkOutput($sformatf("ovr idx %0d", i), 32'(bus.disp_idx), 32'(ovr_idx[i]));
    end
    applyStimulus(1'b0, 0, 1'b0, 1'b0);

    // Async reset in the middle of a dwell
    applyStimulus(1'b0, 0, 1'b1, 1'b0);
    applyStimulus(1'b0, 0, 1'b1, 1'b0);
    checkOutput("pre-reset replaying", 32'(bus.replaying), 1);
    #2 reset_n = 1'b0;
    #1;
    checkAllZero("async reset");
    reset_n = 1'b1;

    // Empty history: replay request ignored, display follows live score
    bus.live_score = SW'(123);
    applyStimulus(1'b0, 0, 1'b1, 1'b0);
    checkOutput("empty replaying", 32'(bus.replaying), 0);
    checkOutput("empty disp live", 32'(bus.disp_score), 123);
    applyStimulus(1'b1, 5, 1'b1, 1'b0);
    bus.wr_en = 1'b0;
    checkOutput("fresh write replaying", 32'(bus.replaying), 0);
    checkOutput("fresh write count", 32'(bus.count), 1);
    checkOutput("fresh write best", 32'(bus.best_score), 5);
    applyStimulus(1'b0, 0, 1'b1, 1'b0);
    checkOutput("resume replaying", 32'(bus.replaying), 1);
    checkOutput("resume disp", 32'(bus.disp_score), 5);
    applyStimulus(1'b0, 0, 1'b0, 1'b0);

    // Clear, then wrap the buffer with 1..5
    applyStimulus(1'b0, 0, 1'b0, 1'b1);
    checkOutput("clear count", 32'(bus.count), 0);
    checkOutput("clear best", 32'(bus.best_score), 0);
    for (int s = 1; s <= 5; s++) begin
      applyStimulus(1'b1, s, 1'b0, 1'b0);
    end
    bus.wr_en = 1'b0;
    checkOutput("wrap count", 32'(bus.count), 4);
    checkOutput("wrap full", 32'(bus.full), 1);
    checkOutput("wrap best", 32'(bus.best_score), 5);
    checkOutput("wrap best_idx", 32'(bus.best_idx), 4);
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1'b0, 0, 1'b1, 1'b0);
      checkOutput($sformatf("wrap val %0d", i), 32'(bus.disp_score), 32'(wrap_v[i / 3]));
      checkOutput($sformatf("wrap idx %0d", i), 32'(bus.disp_idx), 32'(i / 3));
    end
    applyStimulus(1'b0, 0, 1'b0, 1'b0);

    // Clear and write together: clear wins, later replay ignored
    applyStimulus(1'b1, 500, 1'b0, 1'b1);
    bus.wr_en = 1'b0;
    bus.clear = 1'b0;
    checkOutput("clr+wr count", 32'(bus.count), 0);
    checkOutput("clr+wr best", 32'(bus.best_score), 0);
    checkOutput("clr+wr best_idx", 32'(bus.best_idx), 0);
    checkOutput("clr+wr full", 32'(bus.full), 0);
    applyStimulus(1'b0, 0, 1'b1, 1'b0);
    applyStimulus(1'b0, 0, 1'b1, 1'b0);
    checkOutput("clr+wr replaying", 32'(bus.replaying), 0);
    checkOutput("clr+wr disp live", 32'(bus.disp_score), 123);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
